// File: rtl/comparator_bist_if.sv
// Bundles the BIST control/status and the comparator-under-test drive/response wires.
// Latency: none; wires only.
// Backpressure: none; start is a level sampled by the BIST only when it is idle or done.
interface comparator_bist_if;
    // control / status
    logic       start;
    logic       busy;
    logic       done;
    logic       pass;
    logic [4:0] err_cnt;
    logic       fail_valid;
    logic [6:0] first_fail;

    // drive into the comparator under test
    logic       A1;
    logic       A0;
    logic       B1;
    logic       B0;

    // responses from the comparator under test
    logic       A_gt_B;
    logic       A_eq_B;
    logic       A_lt_B;

    // BIST engine side
    modport slave (
        input  start,
        input  A_gt_B,
        input  A_eq_B,
        input  A_lt_B,
        output A1,
        output A0,
        output B1,
        output B0,
        output busy,
        output done,
        output pass,
        output err_cnt,
        output fail_valid,
        output first_fail
    );

    // environment side: issues start, hosts the comparator, reads status
    modport master (
        output start,
        output A_gt_B,
        output A_eq_B,
        output A_lt_B,
        input  A1,
        input  A0,
        input  B1,
        input  B0,
        input  busy,
        input  done,
        input  pass,
        input  err_cnt,
        input  fail_valid,
        input  first_fail
    );
endinterface

// File: rtl/comparator_bist.sv
// Exhaustive 2-bit comparator self-test: drives all 16 {A,B} vectors, checks gt/eq/lt.
// Latency: done rises 16*(SETTLE_CYCLES+2) edges after the edge that samples start.
// Backpressure: start is ignored while busy; results hold in DONE until the next start.
module comparator_bist #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    comparator_bist_if.slave    bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DRIVE  = 3'd1,
        S_SETTLE = 3'd2,
        S_CHECK  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    // Settle count is loaded as a 4-bit value; legal range is 1..15.
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);
    localparam logic [4:0] ERR_MAX     = 5'd16;

    state_t     state_q,      state_d;
    logic [3:0] vec_q,        vec_d;       // next vector to drive
    logic [3:0] drv_q,        drv_d;       // {A1,A0,B1,B0} currently applied
    logic [3:0] cnt_q,        cnt_d;       // settle countdown
    logic [4:0] err_cnt_q,    err_cnt_d;
    logic       fail_valid_q, fail_valid_d;
    logic [6:0] first_fail_q, first_fail_d;

    logic [1:0] exp_a;
    logic [1:0] exp_b;
    logic [2:0] exp_rsp;
    logic [2:0] rsp;
    logic       mismatch;

    // Expected response for the vector on the pins; any deviation (including
    // non-one-hot patterns) is a fail because the whole triple is compared.
    always_comb begin
        exp_a    = drv_q[3:2];
        exp_b    = drv_q[1:0];
        exp_rsp  = {(exp_a > exp_b), (exp_a == exp_b), (exp_a < exp_b)};
        rsp      = {bus.A_gt_B, bus.A_eq_B, bus.A_lt_B};
        mismatch = (rsp != exp_rsp);
    end

    // Sweep sequencing and result accumulation.
    always_comb begin
        state_d      = state_q;
        vec_d        = vec_q;
        drv_d        = drv_q;
        cnt_d        = cnt_q;
        err_cnt_d    = err_cnt_q;
        fail_valid_d = fail_valid_q;
        first_fail_d = first_fail_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                // Pins keep their last value here; a new sweep clears results only.
                if (bus.start) begin
                    state_d      = S_DRIVE;
                    vec_d        = 4'd0;
                    err_cnt_d    = 5'd0;
                    fail_valid_d = 1'b0;
                    first_fail_d = 7'd0;
                end
            end

            S_DRIVE: begin
                drv_d   = vec_q;
                cnt_d   = SETTLE_LOAD;
                state_d = S_SETTLE;
            end

            S_SETTLE: begin
                cnt_d = cnt_q - 4'd1;
                // Leave on the edge where the count reaches zero; <=1 also
                // guards against a zero load so the FSM cannot stall.
                if (cnt_q <= 4'd1) begin
                    state_d = S_CHECK;
                end
            end

            S_CHECK: begin
                if (mismatch) begin
                    if (err_cnt_q < ERR_MAX) begin
                        err_cnt_d = err_cnt_q + 5'd1;
                    end
                    if (!fail_valid_q) begin
                        fail_valid_d = 1'b1;
                        first_fail_d = {drv_q, rsp};
                    end
                end
                if (vec_q == 4'd15) begin
                    state_d = S_DONE;
                end else begin
                    vec_d   = vec_q + 4'd1;
                    state_d = S_DRIVE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; reset aborts any sweep and clears all results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            vec_q        <= 4'd0;
            drv_q        <= 4'd0;
            cnt_q        <= 4'd0;
            err_cnt_q    <= 5'd0;
            fail_valid_q <= 1'b0;
            first_fail_q <= 7'd0;
        end else begin
            state_q      <= state_d;
            vec_q        <= vec_d;
            drv_q        <= drv_d;
            cnt_q        <= cnt_d;
            err_cnt_q    <= err_cnt_d;
            fail_valid_q <= fail_valid_d;
            first_fail_q <= first_fail_d;
        end
    end

    assign bus.A1         = drv_q[3];
    assign bus.A0         = drv_q[2];
    assign bus.B1         = drv_q[1];
    assign bus.B0         = drv_q[0];
    assign bus.busy       = (state_q == S_DRIVE) || (state_q == S_SETTLE) || (state_q == S_CHECK);
    assign bus.done       = (state_q == S_DONE);
    assign bus.pass       = (state_q == S_DONE) && (err_cnt_q == 5'd0);
    assign bus.err_cnt    = err_cnt_q;
    assign bus.fail_valid = fail_valid_q;
    assign bus.first_fail = first_fail_q;

endmodule

// File: tb/tb_comparator_bist.sv
// Bench for comparator_bist: two instances (settle 1 and settle 3) sharing clock and reset.
// Latency: checks done latency of 48 / 80 edges via the monitor.
// Backpressure: exercises start during busy (ignored) and start while done (restart).
module tb_comparator_bist;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    comparator_bist_if if1();
    comparator_bist_if if3();

    comparator_bist #(.SETTLE_CYCLES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    comparator_bist #(.SETTLE_CYCLES(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(if3));

    // Comparator-under-test models: 0 ideal, 1 A_eq_B stuck at 0, 2 gt/lt swapped.
    function automatic logic [2:0] cut_model(input int mode, input logic [3:0] v);
        logic [1:0] a;
        logic [1:0] b;
        logic gt, eq, lt;
        a  = v[3:2];
        b  = v[1:0];
        gt = (a > b);
        eq = (a == b);
        lt = (a < b);
        if (mode == 1) eq = 1'b0;
        if (mode == 2) return {lt, eq, gt};
        return {gt, eq, lt};
    endfunction

    int         mode1;
    logic [2:0] rsp1;
    logic [2:0] rsp3a;
    logic [2:0] rsp3b;

    always_comb rsp1 = cut_model(mode1, {if1.A1, if1.A0, if1.B1, if1.B0});

    // Ideal comparator with a two-cycle response delay for the settle-3 instance.
    always @(posedge clk) begin
        rsp3a <= cut_model(0, {if3.A1, if3.A0, if3.B1, if3.B0});
        rsp3b <= rsp3a;
    end

    assign if1.A_gt_B = rsp1[2];
    assign if1.A_eq_B = rsp1[1];
    assign if1.A_lt_B = rsp1[0];
    assign if3.A_gt_B = rsp3b[2];
    assign if3.A_eq_B = rsp3b[1];
    assign if3.A_lt_B = rsp3b[0];

    // Monitor view of the instance under test.
    logic       sel;
    logic [3:0] m_vec;
    logic       m_busy, m_done, m_pass, m_fv;
    logic [4:0] m_err;
    logic [6:0] m_ff;
    always_comb begin
        m_vec  = sel ? {if3.A1, if3.A0, if3.B1, if3.B0} : {if1.A1, if1.A0, if1.B1, if1.B0};
        m_busy = sel ? if3.busy       : if1.busy;
        m_done = sel ? if3.done       : if1.done;
        m_pass = sel ? if3.pass       : if1.pass;
        m_fv   = sel ? if3.fail_valid : if1.fail_valid;
        m_err  = sel ? if3.err_cnt    : if1.err_cnt;
        m_ff   = sel ? if3.first_fail : if1.first_fail;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s", name);
    endtask

    typedef struct {
        int lat;
        int err;
        int fv;
        int ff;
        int pass;
    } res_t;

    res_t res_q[$];
    int   vec_q[$];

    // Scoreboard monitor: checks each newly driven vector and the result at done.
    int   cyc = 0;
    logic busy_p = 1'b0;
    logic done_p = 1'b0;
    always @(negedge clk) begin
        int   period;
        int   ev;
        res_t er;
        period = sel ? 5 : 3;
        if (!rst_n) begin
            busy_p = 1'b0;
            done_p = 1'b0;
        end else begin
            if (m_busy && !busy_p) cyc = 0;
            else cyc++;
            if (m_busy && cyc >= 1 && ((cyc - 1) % period) == 0) begin
                if (vec_q.size() == 0) fail_now("unexpected_vector");
                else begin
                    ev = vec_q.pop_front();
                    check("drive_vec", m_vec, ev);
                end
            end
            if (m_done && !done_p) begin
                if (res_q.size() == 0) fail_now("unexpected_done");
                else begin
                    er = res_q.pop_front();
                    check("done_latency", cyc, er.lat);
                    check("err_cnt", m_err, er.err);
                    check("fail_valid", m_fv, er.fv);
                    check("first_fail", m_ff, er.ff);
                    check("pass", m_pass, er.pass);
                end
            end
            busy_p = m_busy;
            done_p = m_done;
        end
    end

    task automatic set_start(input logic v);
        if (sel) if3.start = v;
        else     if1.start = v;
    endtask

    task automatic run_sweep(input logic s, input int mode, input bit pulse_busy,
                             input int e_err, input int e_fv, input int e_ff, input int e_pass);
        res_t r;
        int   n;
        sel   = s;
        mode1 = mode;
        for (int v = 0; v < 16; v++) vec_q.push_back(v);
        r.lat  = s ? 80 : 48;
        r.err  = e_err;
        r.fv   = e_fv;
        r.ff   = e_ff;
        r.pass = e_pass;
        res_q.push_back(r);
        @(negedge clk);
        set_start(1'b1);
        @(negedge clk);
        set_start(1'b0);
        check("start_busy", m_busy, 1);
        check("start_done_low", m_done, 0);
        check("start_err_clear", m_err, 0);
        check("start_fv_clear", m_fv, 0);
        n = 0;
        while (!m_done && n < 300) begin
            @(negedge clk);
            if (pulse_busy && (n % 4) == 1 && n < 40) set_start(1'b1);
            else set_start(1'b0);
            n++;
        end
        set_start(1'b0);
        if (!m_done) fail_now("done_timeout");
        repeat (2) @(negedge clk);
        check("done_held", m_done, 1);
        check("vec_q_drained", vec_q.size(), 0);
        check("res_q_drained", res_q.size(), 0);
    endtask

    initial begin
        int n;
        rst_n     = 1'b0;
        if1.start = 1'b0;
        if3.start = 1'b0;
        mode1     = 0;
        sel       = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_vec1", {if1.A1, if1.A0, if1.B1, if1.B0}, 0);
        check("rst_busy1", if1.busy, 0);
        check("rst_done1", if1.done, 0);
        check("rst_pass1", if1.pass, 0);
        check("rst_err1", if1.err_cnt, 0);
        check("rst_fv1", if1.fail_valid, 0);
        check("rst_ff1", if1.first_fail, 0);
        check("rst_busy3", if3.busy, 0);
        check("rst_done3", if3.done, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_busy", if1.busy, 0);
        check("idle_done", if1.done, 0);

        // ideal comparator
        run_sweep(1'b0, 0, 1'b0, 0, 0, 0, 1);
        // A_eq_B stuck at 0: vectors 0,5,10,15 fail; first at vector 0 with response 000
        run_sweep(1'b0, 1, 1'b0, 4, 1, 7'b0000_000, 0);
        // gt/lt swapped with start pulses during busy: 12 fails, first at vector 1 reporting gt
        run_sweep(1'b0, 2, 1'b1, 12, 1, 7'b0001_100, 0);
        // restart from DONE clears previous errors
        run_sweep(1'b0, 0, 1'b0, 0, 0, 0, 1);

        // reset while vector 7 is applied
        mode1 = 0;
        for (int v = 0; v < 8; v++) vec_q.push_back(v);
        @(negedge clk);
        if1.start = 1'b1;
        @(negedge clk);
        if1.start = 1'b0;
        n = 0;
        while ({if1.A1, if1.A0, if1.B1, if1.B0} != 4'd7 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) fail_now("vector7_timeout");
        #1 rst_n = 1'b0;
        #1;
        check("abort_vec", {if1.A1, if1.A0, if1.B1, if1.B0}, 0);
        check("abort_busy", if1.busy, 0);
        check("abort_done", if1.done, 0);
        check("abort_pass", if1.pass, 0);
        check("abort_err", if1.err_cnt, 0);
        check("abort_fv", if1.fail_valid, 0);
        check("abort_ff", if1.first_fail, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("abort_vec_q", vec_q.size(), 0);
        check("post_abort_idle", if1.busy, 0);
        run_sweep(1'b0, 0, 1'b0, 0, 0, 0, 1);

        // settle 3 with two-cycle delayed responses
        run_sweep(1'b1, 0, 1'b0, 0, 0, 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
